// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and fetch sequencer (IDLE/RUN/DONE)
// Optional instruction counter built only when PC_FETCH_INSTR_CNT_EN is defined.
module pc_fetch #(
    parameter int unsigned    D          = 12,
    parameter int             RELATIVE   = 1,
    parameter logic [D-1:0]   START_ADDR = '0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch_en,
    input  logic [1:0]   lut_sel,
    output logic [1:0]   addr_lut,
    input  logic [D-1:0] target,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_valid,
    output logic         done,
    output logic [15:0]  instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [D-1:0] pc_next;
    logic [D-1:0] branch_pc;

    assign addr_lut = lut_sel;

    // The target table sits inside this path; a D-bit add wraps naturally
    // and also treats target as two's complement.
    generate
        if (RELATIVE != 0) begin : g_rel
            assign branch_pc = prog_ctr + target;
        end else begin : g_abs
            assign branch_pc = target;
        end
    endgenerate

    assign fetch_valid = (state == RUN) && !stall;
    assign done        = (state == DONE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            prog_ctr <= START_ADDR;
        end else begin
            state    <= state_next;
            prog_ctr <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = prog_ctr;
        case (state)
            IDLE: begin
                pc_next = START_ADDR;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_next = DONE;
                    end else if (branch_en) begin
                        pc_next = branch_pc;
                    end else begin
                        pc_next = prog_ctr + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = START_ADDR;
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = START_ADDR;
            end
        endcase
    end

`ifdef PC_FETCH_INSTR_CNT_EN
    logic [15:0] cnt_q;
    logic        cnt_restart;

    assign cnt_restart = start && ((state == IDLE) || (state == DONE));

    // Counts every unstalled RUN cycle, halting instruction included; saturates.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= 16'h0000;
        end else if (cnt_restart) begin
            cnt_q <= 16'h0000;
        end else if (fetch_valid && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = 16'h0000;
`endif

endmodule
